// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: glyph table, bit positions, FSM state type
// and the forward encoder, so both ends of the link use one table.
package seg_pkg;

    localparam int unsigned SEG_A_BIT  = 0;
    localparam int unsigned SEG_B_BIT  = 1;
    localparam int unsigned SEG_C_BIT  = 2;
    localparam int unsigned SEG_D_BIT  = 3;
    localparam int unsigned SEG_E_BIT  = 4;
    localparam int unsigned SEG_F_BIT  = 5;
    localparam int unsigned SEG_G_BIT  = 6;
    localparam int unsigned SEG_DP_BIT = 7;
    localparam int unsigned SEG_SEL_LSB = 8;
    localparam int unsigned SEG_SEL_MSB = 11;

    localparam int unsigned SEG_BUS_W = 12;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-high G..A pattern for each nibble value, entry [n] is glyph n.
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        StDone   = 2'd0,
        StSettle = 2'd1,
        StEmit   = 2'd2
    } seg_state_e;

    // Forward encoder: nibble, decimal point and select field to active-low bus.
    function automatic logic [SEG_BUS_W-1:0] seg_encode(input logic [3:0] nibble,
                                                         input logic       dp,
                                                         input logic [3:0] sel_n);
        logic [SEG_BUS_W-1:0] bus;
        bus = '1;
        bus[SEG_G_BIT:SEG_A_BIT]     = ~SEG_GLYPH[nibble];
        bus[SEG_DP_BIT]              = ~dp;
        bus[SEG_SEL_MSB:SEG_SEL_LSB] = sel_n;
        return bus;
    endfunction

endpackage

// File: rtl/seg_readback_if.sv
// Segment-bus input and decoded-result handshake of seg_readback.
interface seg_readback_if;
    import seg_pkg::*;

    logic [SEG_BUS_W-1:0] seg_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_nibble;
    logic                 out_dp;
    logic [3:0]           out_sel;
    logic                 out_err;
    logic [7:0]           err_count;

    modport slave (
        input  seg_in,
        input  out_ready,
        output out_valid,
        output out_nibble,
        output out_dp,
        output out_sel,
        output out_err,
        output err_count
    );

    modport master (
        output seg_in,
        output out_ready,
        input  out_valid,
        input  out_nibble,
        input  out_dp,
        input  out_sel,
        input  out_err,
        input  err_count
    );

endinterface

// File: rtl/seg7_inv_lut.sv
// Inverse glyph lookup: active-high G..A segments to {hit, nibble}.
module seg7_inv_lut
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_hit,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_hit    = 1'b0;
        o_nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == SEG_GLYPH[i]) begin
                o_hit    = 1'b1;
                o_nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_readback.sv
// Samples an active-low segment bus, waits for a stable pattern, decodes it once
// and hands the result out over valid/ready, counting unrecognised glyphs.
module seg_readback
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    seg_readback_if.slave  bus
);

    localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

    seg_state_e           r_state;
    seg_state_e           w_state_d;
    logic [SEG_BUS_W-1:0] r_seg_q;
    logic [7:0]           r_cnt;
    logic                 r_chg;

    logic                 r_valid;
    logic [3:0]           r_nibble;
    logic                 r_dp;
    logic [3:0]           r_sel;
    logic                 r_err;
    logic [7:0]           r_err_count;

    logic                 w_diff;
    logic                 w_settled;
    logic                 w_blank;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_hit;
    logic [3:0]           w_lut_nibble;
    logic [6:0]           w_seg_ah;

    assign w_seg_ah  = ~r_seg_q[SEG_G_BIT:SEG_A_BIT];
    assign w_diff    = (bus.seg_in != r_seg_q);
    assign w_settled = !w_diff && (r_cnt == CntMax);
    assign w_blank   = (r_seg_q[SEG_G_BIT:SEG_A_BIT] == SEG_BLANK);
    assign w_accept  = r_valid && bus.out_ready;

    seg7_inv_lut u_lut (
        .i_seg    (w_seg_ah),
        .o_hit    (w_hit),
        .o_nibble (w_lut_nibble)
    );

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        unique case (r_state)
            StDone: begin
                if (w_diff) begin
                    w_state_d = StSettle;
                end
            end
            StSettle: begin
                if (w_settled) begin
                    if (w_blank) begin
                        w_state_d = StDone;
                    end else begin
                        w_load    = 1'b1;
                        w_state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                // A change seen while stalled (or on the accept cycle itself) is re-evaluated.
                if (w_accept) begin
                    w_state_d = (r_chg || w_diff) ? StSettle : StDone;
                end
            end
            default: w_state_d = StDone;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StDone;
            r_seg_q <= '1;
            r_cnt   <= 8'd0;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_seg_q <= bus.seg_in;
            if (w_diff) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != CntMax) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == StEmit && !w_accept) begin
                r_chg <= r_chg | w_diff;
            end else begin
                r_chg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_nibble    <= 4'h0;
            r_dp        <= 1'b0;
            r_sel       <= 4'h0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            if (w_load) begin
                r_valid  <= 1'b1;
                r_nibble <= w_hit ? w_lut_nibble : 4'h0;
                r_dp     <= ~r_seg_q[SEG_DP_BIT];
                r_sel    <= r_seg_q[SEG_SEL_MSB:SEG_SEL_LSB];
                r_err    <= ~w_hit;
                if (!w_hit && r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end else if (r_state == StEmit && w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = r_valid;
    assign bus.out_nibble = r_nibble;
    assign bus.out_dp     = r_dp;
    assign bus.out_sel    = r_sel;
    assign bus.out_err    = r_err;
    assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_seg_readback.sv
// Directed bench for seg_readback with STABLE_CYCLES = 4.
module tb_seg_readback;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seg_readback_if bus ();

    seg_readback #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.seg_in    = 12'hFFF;
        bus.out_ready = 1'b0;
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_nibble !== 4'h0 || bus.out_dp !== 1'b0 ||
            bus.out_sel !== 4'h0 || bus.out_err !== 1'b0 || bus.err_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: got v=%b n=%h dp=%b sel=%h err=%b cnt=%0d, want all 0",
                     bus.out_valid, bus.out_nibble, bus.out_dp, bus.out_sel, bus.out_err,
                     bus.err_count);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_blank: out_valid=%b, want 0", bus.out_valid);
        end
    endtask

    task automatic test_clean_decode();
        bus.out_ready = 1'b1;
        bus.seg_in    = 12'hFF9;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== (i == 5)) begin
                n_fail++;
                $display("FAIL clean_valid cycle %0d: got %b, want %b", i, bus.out_valid, i == 5);
            end
            if (i == 5) begin
                n_checks++;
                if (bus.out_nibble !== 4'h1 || bus.out_dp !== 1'b0 || bus.out_err !== 1'b0 ||
                    bus.out_sel !== 4'hF) begin
                    n_fail++;
                    $display("FAIL clean_data: got n=%h dp=%b err=%b sel=%h, want 1 0 0 F",
                             bus.out_nibble, bus.out_dp, bus.out_err, bus.out_sel);
                end
            end
        end
    endtask

    task automatic test_glitch();
        bus.seg_in = 12'hF80;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_early: out_valid=%b, want 0", bus.out_valid);
            end
        end
        bus.seg_in = 12'hF90;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== (i == 5)) begin
                n_fail++;
                $display("FAIL glitch_valid cycle %0d: got %b, want %b", i, bus.out_valid, i == 5);
            end
            if (i == 5) begin
                n_checks++;
                if (bus.out_nibble !== 4'h9 || bus.out_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_data: got n=%h err=%b, want 9 0",
                             bus.out_nibble, bus.out_err);
                end
            end
        end
    endtask

    task automatic test_invalid_blank();
        bit ok;
        n_checks++;
        if (bus.err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL errcnt_pre: got %0d, want 0", bus.err_count);
        end
        bus.seg_in = 12'hFFE;
        wait_valid(12, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL invalid_timeout: no out_valid within 12 cycles");
        end
        n_checks++;
        if (bus.out_err !== 1'b1 || bus.out_nibble !== 4'h0 || bus.err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL invalid_data: got err=%b n=%h cnt=%0d, want 1 0 1",
                     bus.out_err, bus.out_nibble, bus.err_count);
        end
        bus.seg_in = 12'hFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL blank_valid cycle %0d: got %b, want 0", i, bus.out_valid);
            end
        end
        for (int e = 0; e < 260; e++) begin
            bus.seg_in = e[0] ? 12'hFFE : 12'hFFD;
            wait_valid(12, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL errloop_timeout: error %0d not emitted", e);
                break;
            end
        end
        n_checks++;
        if (bus.err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL errcnt_sat: got %0d, want 255", bus.err_count);
        end
    endtask

    task automatic test_back_pressure();
        bit ok;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.seg_in    = 12'hF88;
        wait_valid(12, ok);
        n_checks++;
        if (!ok || bus.out_nibble !== 4'hA || bus.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_first: ok=%b n=%h err=%b, want 1 A 0", ok, bus.out_nibble,
                     bus.out_err);
        end
        bus.seg_in = 12'hFC6;
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_nibble !== 4'hA) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b n=%h, want 1 A", bus.out_valid, bus.out_nibble);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: out_valid=%b, want 0", bus.out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_nibble !== 4'hC) begin
            n_fail++;
            $display("FAIL bp_second: got v=%b n=%h, want 1 C", bus.out_valid, bus.out_nibble);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_third cycle %0d: out_valid=%b, want 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        bit ok;
        bus.out_ready = 1'b0;
        bus.seg_in    = 12'h379;
        wait_valid(12, ok);
        n_checks++;
        if (!ok || bus.out_nibble !== 4'h1 || bus.out_dp !== 1'b1 || bus.out_sel !== 4'h3) begin
            n_fail++;
            $display("FAIL rst_pre: ok=%b n=%h dp=%b sel=%h, want 1 1 1 3", ok, bus.out_nibble,
                     bus.out_dp, bus.out_sel);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_nibble !== 4'h0 || bus.out_dp !== 1'b0 ||
            bus.out_sel !== 4'h0 || bus.out_err !== 1'b0 || bus.err_count !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b n=%h dp=%b sel=%h err=%b cnt=%0d, want all 0",
                     bus.out_valid, bus.out_nibble, bus.out_dp, bus.out_sel, bus.out_err,
                     bus.err_count);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== (i == 5)) begin
                n_fail++;
                $display("FAIL rst_reemit cycle %0d: got %b, want %b", i, bus.out_valid, i == 5);
            end
            if (i == 5) begin
                n_checks++;
                if (bus.out_nibble !== 4'h1 || bus.out_dp !== 1'b1 || bus.out_sel !== 4'h3) begin
                    n_fail++;
                    $display("FAIL rst_reemit_data: got n=%h dp=%b sel=%h, want 1 1 3",
                             bus.out_nibble, bus.out_dp, bus.out_sel);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_clean_decode();
        test_glitch();
        test_invalid_blank();
        test_back_pressure();
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_readback.md
# seg_readback

Receive-side counterpart of the hex-to-seven-segment encoder. It samples a 12-bit active-low segment bus, waits until the pattern has been stable for a programmable number of cycles, and decodes it back to a 4-bit nibble plus decimal point. Each new pattern is delivered once over a valid/ready handshake. Unrecognised glyphs are flagged and counted. It sits on the board-test/debug path, either looped back from the segment outputs or fed from a captured display bus.

## Interface
- `STABLE_CYCLES`, default 4: consecutive equal samples required before decode; legal range 1..255.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `seg_in`  in  12  segment bus, MSB~LSB = SEG[3:0], DP, G, F, E, D, C, B, A. All bits are active-low. SEG[3:0] is captured but not decoded.
- `out_valid`  out  1  decoded result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_nibble`  out  4  decoded hex value; 0 when `out_err` = 1.
- `out_dp`  out  1  decimal point, active-high (inverse of bit 7).
- `out_sel`  out  4  SEG field as sampled (raw).
- `out_err`  out  1  pattern is non-blank and not in the glyph table.
- `err_count`  out  8  count of emitted error results; saturates at 255.

## Operation
- **Sample register:** `seg_q <= seg_in` every cycle.
- **Stability counter `cnt`:**
  - Cleared to 0 when `seg_in != seg_q`.
  - Otherwise increments, saturating at `STABLE_CYCLES-1`.
- **Blank pattern:** `seg_in[6:0]` = 7'h7F (all segments off). A blank pattern is never emitted.
- **Glyph table:** active-high G..A patterns 3f, 06, 5b, 4f, 66, 6d, 7d, 07, 7f, 6f, 77, 7c, 39, 5e, 79, 71 map to nibbles 0..F. Decode operates on `~seg_in[6:0]`.
- **State machine:**
  - DONE: waits for `seg_in != seg_q`, then moves to SETTLE.
  - SETTLE, when `seg_in == seg_q` and `cnt == STABLE_CYCLES-1`:
    - If the pattern is blank, go to DONE with no output.
    - Otherwise latch `out_nibble`, `out_dp`, `out_sel` and `out_err`, set `out_valid`, and go to EMIT.
    - If `out_err` is set, increment `err_count` (saturating).
  - SETTLE, when `seg_in != seg_q`: stay in SETTLE; `cnt` restarts.
  - EMIT: output registers are frozen and `out_valid` is held until `out_valid && out_ready`. On that cycle `out_valid` drops next edge. The next state is SETTLE if `chg` is set, otherwise DONE. `chg` is then cleared.
- **Change flag `chg`:** set in EMIT whenever `seg_in != seg_q`. This ensures a pattern that changes during a stalled handshake is re-evaluated after the handshake. Intermediate patterns are dropped and not queued.
- **Re-emission rule:** the same pattern is never emitted twice without an intervening change.

## Timing
- **Reset values:**
  - state = DONE, `seg_q` = 12'hFFF, `cnt` = 0, `chg` = 0.
  - `out_valid` = 0, `out_nibble` = 0, `out_dp` = 0, `out_sel` = 0, `out_err` = 0, `err_count` = 0.
- **Latency:** a new pattern P is present at the first edge E0 and held through edge E(STABLE_CYCLES). `out_valid` is high in the cycle following edge E(STABLE_CYCLES).
- **Glitches:** any change before that edge restarts the count from 0.
- **Handshake:**
  - `out_ready` may be high before `out_valid`.
  - Acceptance is the edge where both are high. With `out_ready` tied high, `out_valid` is a 1-cycle pulse.
  - `out_valid` never drops without acceptance, except on reset.
- **Reset mid-operation:** asynchronous `rst` clears everything immediately, including a pending EMIT. The result is lost.
- All outputs are registered; there is no combinational path from `seg_in` or `out_ready` to any output.

## Structure
- **Package `seg_pkg`:**
  - 16-entry glyph constant array.
  - `SEG_BLANK` = 7'h7F.
  - Bit-position constants for A..G, DP and SEG.
  - The encoder is moved onto the same package so both ends share one table.
- **Sub-module `seg7_inv_lut`:** combinational, 7-bit active-high segments in, outputs `{hit, nibble[3:0]}`. It is instantiated once on `seg_q`.
- **Top level:** contains the counter, FSM, output registers and error counter.

## Test plan
- **Clean decode:** hold `seg_in` = ~12'h06 for 10 cycles with `out_ready` = 1. Expect exactly one `out_valid` pulse at cycle 5 after the change (`STABLE_CYCLES` = 4), `out_nibble` = 1, `out_dp` = 0, `out_err` = 0, `out_sel` = 4'hF.
- **Glitch:** ~12'h7f held for 2 cycles, then ~12'h6f held. Expect a single result, `out_nibble` = 9, with latency counted from the second change; no output for 8.
- **Invalid glyph and blank:**
  - Apply `seg_in` = 12'hFFE (segment A only) held. Expect `out_err` = 1, `out_nibble` = 0, `err_count` = 1.
  - Then apply 12'hFFF held. Expect no output.
  - Force 260 errors. Expect `err_count` = 255.
- **Back-pressure:**
  - `out_ready` = 0; apply ~12'h77, then ~12'h39 while EMIT is pending. Expect `out_valid` held with `out_nibble` = A.
  - Raise `out_ready`. Expect acceptance of A, then C emitted after re-settling. Expect no third emission.
- **Reset mid-EMIT:** assert `rst` while `out_valid` = 1. Expect all outputs 0 asynchronously. After release with an unchanged non-blank input, expect a fresh emission after `STABLE_CYCLES`+1 edges.
